// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access unit
// Issues req/ack bus transactions, steers store lanes, extends loads, stalls pipeline.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUO_MEM,
  input  logic [31:0] Datao_MEM,
  input  logic        WR_MEM,
  input  logic        mem_r_MEM,
  input  logic [2:0]  u_b_h_w_MEM,
  input  logic        isFlushed,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data_MEM,
  output logic        stall_mem,
  output logic        misalign_exp,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        misaligned, access, pending, timeout_hit;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        ld_pend;
  logic [1:0]  ld_off;
  logic [2:0]  ld_fn;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    misaligned = 1'b0;
    case (u_b_h_w_MEM)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = ALUO_MEM[0];
      3'b010:         misaligned = |ALUO_MEM[1:0];
      default:        misaligned = 1'b1;
    endcase
  end

  assign access       = WR_MEM | mem_r_MEM;
  assign pending      = access & ~isFlushed & ~misaligned;
  assign misalign_exp = access & ~isFlushed & misaligned;
  assign timeout_hit  = (cnt == 8'(TIMEOUT - 1));

  // Only aligned offsets reach the bus, so a plain shift yields the lane mask.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = Datao_MEM;
    case (u_b_h_w_MEM[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALUO_MEM[1:0];
        st_wdata = {4{Datao_MEM[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << ALUO_MEM[1:0];
        st_wdata = {2{Datao_MEM[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = Datao_MEM;
      end
    endcase
  end

  assign ld_byte = dmem_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = dmem_rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = dmem_rdata;
    case (ld_fn)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending) state_nxt = WAIT;
      WAIT:    if (dmem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_mem = 1'b0;
    case (state)
      IDLE:    stall_mem = pending;
      WAIT:    stall_mem = 1'b1;
      default: stall_mem = 1'b0;
    endcase
  end

  // Width and lane are captured at issue so the load result does not depend
  // on the latch contents seen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_be       <= 4'h0;
      dmem_wdata    <= 32'h0;
      load_data_MEM <= 32'h0;
      bus_err       <= 1'b0;
      cnt           <= 8'h0;
      ld_pend       <= 1'b0;
      ld_off        <= 2'b00;
      ld_fn         <= 3'b000;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            dmem_req   <= 1'b1;
            dmem_we    <= WR_MEM;
            dmem_addr  <= {ALUO_MEM[31:2], 2'b00};
            dmem_be    <= WR_MEM ? st_be : 4'b1111;
            dmem_wdata <= WR_MEM ? st_wdata : 32'h0;
            cnt        <= 8'h0;
            ld_pend    <= ~WR_MEM;
            ld_off     <= ALUO_MEM[1:0];
            ld_fn      <= u_b_h_w_MEM;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (ld_pend) load_data_MEM <= ld_ext;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
            if (ld_pend) load_data_MEM <= 32'h0;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit
// Vector table of single accesses plus hand sequences for timeout, reset and back-to-back.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUO_MEM, Datao_MEM;
  logic        WR_MEM, mem_r_MEM, isFlushed;
  logic [2:0]  u_b_h_w_MEM;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data_MEM;
  logic [3:0]  dmem_be;
  logic        stall_mem, misalign_exp, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ALUO_MEM(ALUO_MEM), .Datao_MEM(Datao_MEM),
    .WR_MEM(WR_MEM), .mem_r_MEM(mem_r_MEM),
    .u_b_h_w_MEM(u_b_h_w_MEM), .isFlushed(isFlushed),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .load_data_MEM(load_data_MEM), .stall_mem(stall_mem),
    .misalign_exp(misalign_exp), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic        rd;
    logic [2:0]  fn;
    logic        fl;
    logic [3:0]  waits;
    logic [31:0] rdata;
    logic        e_mis;
    logic [3:0]  e_stall;
    logic [3:0]  e_reqc;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        chk_ld;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bubble();
    WR_MEM = 1'b0; mem_r_MEM = 1'b0; isFlushed = 1'b0;
    u_b_h_w_MEM = 3'b010; ALUO_MEM = 32'h0; Datao_MEM = 32'h0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic r, input logic [2:0] f, input logic fl);
    ALUO_MEM = a; Datao_MEM = d; WR_MEM = w; mem_r_MEM = r;
    u_b_h_w_MEM = f; isFlushed = fl;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int stalls, reqc;
    logic got_done, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0] c_be;
    string tag;
    stalls = 0; reqc = 0; got_done = 1'b0;
    c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0;
    tag = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    drive(v.addr, v.data, v.wr, v.rd, v.fn, v.fl);
    dmem_ack = 1'b0; dmem_rdata = v.rdata;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_misalign"}, {31'h0, misalign_exp}, {31'h0, v.e_mis});
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (reqc == 0) begin
          c_we = dmem_we; c_addr = dmem_addr; c_be = dmem_be; c_wdata = dmem_wdata;
        end
        if (reqc == int'(v.waits)) dmem_ack = 1'b1;
        reqc++;
      end
      if (stall_mem) stalls++;
      else begin
        got_done = 1'b1;
        break;
      end
    end
    dmem_ack = 1'b0;
    chk({tag, "_finished"}, {31'h0, got_done}, 32'h1);
    chk({tag, "_stalls"}, 32'(stalls), 32'(v.e_stall));
    chk({tag, "_req_cycles"}, 32'(reqc), 32'(v.e_reqc));
    if (v.e_reqc != 0) begin
      chk({tag, "_we"}, {31'h0, c_we}, {31'h0, v.e_we});
      chk({tag, "_addr"}, c_addr, v.e_addr);
      chk({tag, "_be"}, {28'h0, c_be}, {28'h0, v.e_be});
      if (v.e_we) chk({tag, "_wdata"}, c_wdata, v.e_wdata);
    end
    if (v.chk_ld) chk({tag, "_load"}, load_data_MEM, v.e_ld);
    bubble();
  endtask

  initial begin
    int reqc, errc, rises, req_in_done, ldi;
    logic prev_req;
    logic [31:0] exp_ld [2];

    // addr, data, wr, rd, fn, fl, waits, rdata, mis, stall, reqc, we, eaddr, be, wdata, chk_ld, e_ld
    vecs[0]  = '{32'h100, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 4'd0, 32'hDEADBEEF,
                 1'b0, 4'd2, 4'd1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{32'h203, 32'h0, 1'b0, 1'b1, 3'b000, 1'b0, 4'd0, 32'h80FF1234,
                 1'b0, 4'd2, 4'd1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1, 32'hFFFFFF80};
    vecs[2]  = '{32'h203, 32'h0, 1'b0, 1'b1, 3'b100, 1'b0, 4'd0, 32'h80FF1234,
                 1'b0, 4'd2, 4'd1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1, 32'h00000080};
    vecs[3]  = '{32'h202, 32'h0, 1'b0, 1'b1, 3'b101, 1'b0, 4'd0, 32'h80FF1234,
                 1'b0, 4'd2, 4'd1, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1, 32'h000080FF};
    vecs[4]  = '{32'h202, 32'h0, 1'b0, 1'b1, 3'b001, 1'b0, 4'd1, 32'h80FF1234,
                 1'b0, 4'd3, 4'd2, 1'b0, 32'h200, 4'hF, 32'h0, 1'b1, 32'hFFFF80FF};
    vecs[5]  = '{32'h46, 32'h1234ABCD, 1'b1, 1'b0, 3'b001, 1'b0, 4'd3, 32'h0,
                 1'b0, 4'd5, 4'd4, 1'b1, 32'h44, 4'hC, 32'hABCDABCD, 1'b1, 32'hFFFF80FF};
    vecs[6]  = '{32'h102, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd0, 4'd0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hFFFF80FF};
    vecs[7]  = '{32'h102, 32'h0, 1'b0, 1'b1, 3'b010, 1'b1, 4'd0, 32'h0,
                 1'b0, 4'd0, 4'd0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[8]  = '{32'h101, 32'hA5, 1'b1, 1'b1, 3'b000, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd2, 4'd1, 1'b1, 32'h100, 4'h2, 32'hA5A5A5A5, 1'b1, 32'hFFFF80FF};
    vecs[9]  = '{32'h8, 32'h11223344, 1'b1, 1'b0, 3'b010, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd2, 4'd1, 1'b1, 32'h8, 4'hF, 32'h11223344, 1'b1, 32'hFFFF80FF};
    vecs[10] = '{32'h0, 32'h0, 1'b0, 1'b1, 3'b011, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd0, 4'd0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[11] = '{32'h0, 32'h0, 1'b1, 1'b0, 3'b111, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd0, 4'd0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[12] = '{32'h3, 32'h5A, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd2, 4'd1, 1'b1, 32'h0, 4'h8, 32'h5A5A5A5A, 1'b1, 32'hFFFF80FF};

    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    bubble();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall_mem}, 32'h0);
    chk("rst_load", load_data_MEM, 32'h0);
    chk("rst_be", {28'h0, dmem_be}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // stray ack with nothing outstanding must be ignored
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_req", {31'h0, dmem_req}, 32'h0);
    chk("stray_ack_load", load_data_MEM, 32'hFFFF80FF);

    // timeout on a load: 16 request cycles, single bus_err pulse, result cleared
    @(posedge clk); #1;
    drive(32'h300, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0);
    reqc = 0; errc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dmem_req) reqc++;
      if (bus_err) begin
        errc++;
        chk("to_stall_in_done", {31'h0, stall_mem}, 32'h0);
        chk("to_load_zero", load_data_MEM, 32'h0);
        bubble();
      end
    end
    chk("to_req_cycles", 32'(reqc), 32'd16);
    chk("to_err_pulses", 32'(errc), 32'd1);

    // reset while waiting aborts the transaction
    @(posedge clk); #1;
    drive(32'h310, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0);
    repeat (4) @(negedge clk);
    chk("rw_req_before", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1;
    bubble();
    @(negedge clk);
    rst = 1'b0;
    chk("rw_req_after", {31'h0, dmem_req}, 32'h0);
    chk("rw_stall_after", {31'h0, stall_mem}, 32'h0);
    @(negedge clk);
    chk("rw_req_later", {31'h0, dmem_req}, 32'h0);

    // back-to-back loads advancing only when stall_mem is low
    exp_ld[0] = 32'h11111111;
    exp_ld[1] = 32'h22222222;
    ldi = 0; rises = 0; req_in_done = 0; prev_req = 1'b0;
    @(posedge clk); #1;
    drive(32'h400, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (dmem_req && !prev_req) rises++;
      prev_req = dmem_req;
      if (dmem_req) begin
        dmem_ack = 1'b1;
        dmem_rdata = (ldi == 0) ? exp_ld[0] : exp_ld[1];
      end
      if (!stall_mem && dmem_req) req_in_done++;
      if (!stall_mem && ldi < 2 && !misalign_exp && (WR_MEM || mem_r_MEM)) begin
        chk($sformatf("b2b_load%0d", ldi), load_data_MEM, exp_ld[ldi]);
        ldi++;
        if (ldi == 1) drive(32'h404, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0);
        else bubble();
      end
    end
    dmem_ack = 1'b0;
    chk("b2b_completed", 32'(ldi), 32'd2);
    chk("b2b_issues", 32'(rises), 32'd2);
    chk("b2b_req_when_not_stalled", 32'(req_in_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
